// File: rtl/conv_array_ctrl_pkg.sv
// Shared conv kernel parameters: data width, default geometry, FSM encoding
// and width helpers used by the array controller and its tap counter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package conv_array_ctrl_pkg;

  localparam int DATA_WIDTH      = `DATA_WIDTH;
  localparam int ARRAY_SIZE_DEF  = 6;
  localparam int KERNEL_SIZE_DEF = 3;
  localparam int MAC_LATENCY_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACCUM  = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  // Never let a counter collapse to zero bits when the range is 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tap_w(input int k);
    return clog2_min1(k * k);
  endfunction

  function automatic int idx_w(input int k);
    return clog2_min1(k);
  endfunction

  localparam int TAP_W_DEF = tap_w(KERNEL_SIZE_DEF);
  localparam int IDX_W_DEF = idx_w(KERNEL_SIZE_DEF);

endpackage

// File: rtl/conv_array_ctrl_tap_counter.sv
// Row-major window walker: tap index plus separate row/col counters, so the
// line cache offsets need no divide or modulo.
module conv_tap_counter
  import conv_array_ctrl_pkg::*;
#(
  parameter  int KERNEL_SIZE = KERNEL_SIZE_DEF,
  localparam int TAP_W       = tap_w(KERNEL_SIZE),
  localparam int IDX_W       = idx_w(KERNEL_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [TAP_W-1:0] tap,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(KERNEL_SIZE * KERNEL_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KERNEL_SIZE - 1);

  assign last = (tap == TAP_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      tap <= '0;
      row <= '0;
      col <= '0;
    end else if (enable) begin
      // Wrap on the final tap so the offsets read zero once the window ends.
      if (last) begin
        tap <= '0;
        row <= '0;
        col <= '0;
      end else begin
        tap <= tap + 1'b1;
        if (col == IDX_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_array_ctrl.sv
// Kernel array sequencer: clear, stream KERNEL_SIZE^2 taps, wait out the MAC
// pipeline, then capture the array bus and hand it off over valid/ready.
module conv_array_ctrl
  import conv_array_ctrl_pkg::*;
#(
  parameter  int ARRAY_SIZE  = ARRAY_SIZE_DEF,
  parameter  int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter  int MAC_LATENCY = MAC_LATENCY_DEF,
  localparam int TAP_W       = tap_w(KERNEL_SIZE),
  localparam int IDX_W       = idx_w(KERNEL_SIZE),
  localparam int BUS_W       = ARRAY_SIZE * DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_clear,
  output logic             o_pixel_req,
  output logic [TAP_W-1:0] o_weight_addr,
  output logic [IDX_W-1:0] o_tap_row,
  output logic [IDX_W-1:0] o_tap_col,
  input  logic [BUS_W-1:0] i_array_bus,
  output logic [BUS_W-1:0] o_result_bus,
  output logic             o_result_valid,
  input  logic             i_result_ready
);

  localparam int DRN_W = clog2_min1(MAC_LATENCY);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(MAC_LATENCY - 1);

  state_t state, state_nxt;
  logic   tap_last;
  logic   drain_last;
  logic   capture;
  logic [DRN_W-1:0] drain_cnt;
  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] result_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      S_IDLE:   if (i_start) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_ACCUM;
      S_ACCUM:  if (tap_last) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (drain_last) begin
          capture   = 1'b1;
          state_nxt = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        // A start coincident with the handshake chains straight into a new job.
        if (i_result_ready) state_nxt = i_start ? S_CLEAR : S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Held in clear outside ACCUM so the tap offsets read zero there.
  conv_tap_counter #(
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_tap_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != S_ACCUM),
    .enable (state == S_ACCUM),
    .tap    (o_weight_addr),
    .row    (o_tap_row),
    .col    (o_tap_col),
    .last   (tap_last)
  );

  assign drain_last = (drain_cnt == DRN_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || state != S_DRAIN) drain_cnt <= '0;
    else if (!drain_last)           drain_cnt <= drain_cnt + 1'b1;
  end

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    always_ff @(posedge clk) begin
      if (!rst_n)       result_q[g] <= '0;
      else if (capture) result_q[g] <= i_array_bus[g*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_result_bus   = result_q;
  assign o_busy         = (state != S_IDLE);
  assign o_clear        = (state == S_CLEAR);
  assign o_pixel_req    = (state == S_ACCUM);
  assign o_result_valid = (state == S_OUTPUT);

endmodule

// File: tb/tb_conv_array_ctrl.sv
// Directed bench for conv_array_ctrl: default 3x3/latency-2 instance plus a
// 5x5/latency-3 instance sharing clock, reset and array bus.
module tb_conv_array_ctrl;

  localparam int DW    = 16;
  localparam int LANES = 6;
  localparam int BUS_W = LANES * DW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_start;
  logic             i_result_ready;
  logic [15:0]      salt;
  logic [BUS_W-1:0] i_array_bus;

  logic             o_busy, o_clear, o_pixel_req, o_result_valid;
  logic [3:0]       o_weight_addr;
  logic [1:0]       o_tap_row, o_tap_col;
  logic [BUS_W-1:0] o_result_bus;

  logic             s5_start;
  logic             s5_ready;
  logic             b5_busy, b5_clear, b5_pix, b5_valid;
  logic [4:0]       b5_addr;
  logic [2:0]       b5_row, b5_col;
  logic [BUS_W-1:0] b5_bus;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int clr_seen = 0;
  int pix_seen = 0;

  always #5 clk = ~clk;

  // Array model: lane k presents 0x0101*k offset by a per-job salt.
  function automatic logic [BUS_W-1:0] model(input logic [15:0] s);
    logic [BUS_W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*DW +: DW] = 16'(16'h0101 * k) + s;
    return r;
  endfunction

  assign i_array_bus = model(salt);

  conv_array_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(o_busy),
    .o_clear(o_clear), .o_pixel_req(o_pixel_req), .o_weight_addr(o_weight_addr),
    .o_tap_row(o_tap_row), .o_tap_col(o_tap_col), .i_array_bus(i_array_bus),
    .o_result_bus(o_result_bus), .o_result_valid(o_result_valid),
    .i_result_ready(i_result_ready)
  );

  conv_array_ctrl #(.KERNEL_SIZE(5), .MAC_LATENCY(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .i_start(s5_start), .o_busy(b5_busy),
    .o_clear(b5_clear), .o_pixel_req(b5_pix), .o_weight_addr(b5_addr),
    .o_tap_row(b5_row), .o_tap_col(b5_col), .i_array_bus(i_array_bus),
    .o_result_bus(b5_bus), .o_result_valid(b5_valid), .i_result_ready(s5_ready)
  );

  always @(negedge clk) begin
    if (o_clear)     clr_seen++;
    if (o_pixel_req) pix_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One default-geometry job; cycle N is the cycle i_start is driven.
  task automatic do_job(input int hold, input int pulse_tap,
                        input bit pre_started, input bit b2b_next);
    logic [BUS_W-1:0] exp_bus;
    i_result_ready = (hold == 0);
    if (!pre_started) begin
      i_start = 1'b1;
      step();
    end
    i_start = 1'b0;
    chk("clear_n1", o_clear, 1);
    chk("clear_no_pix", o_pixel_req, 0);
    chk("clear_busy", o_busy, 1);
    step();
    for (int t = 0; t < 9; t++) begin
      chk("tap_pix", o_pixel_req, 1);
      chk("tap_addr", o_weight_addr, t);
      chk("tap_row", o_tap_row, t / 3);
      chk("tap_col", o_tap_col, t % 3);
      chk("tap_no_clear", o_clear, 0);
      i_start = (t == pulse_tap);
      step();
    end
    i_start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("drain_pix", o_pixel_req, 0);
      chk("drain_valid", o_result_valid, 0);
      chk("drain_addr", o_weight_addr, 0);
      chk("drain_busy", o_busy, 1);
      step();
    end
    exp_bus = model(salt);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", o_result_valid, 1);
      chk("hold_bus", o_result_bus, exp_bus);
      salt = salt + 16'h0111;
      step();
    end
    i_result_ready = 1'b1;
    chk("out_valid", o_result_valid, 1);
    chk("out_bus", o_result_bus, exp_bus);
    if (b2b_next) i_start = 1'b1;
    step();
    if (!b2b_next) begin
      chk("post_busy", o_busy, 0);
      chk("post_valid", o_result_valid, 0);
      chk("post_bus_held", o_result_bus, exp_bus);
    end
  endtask

  initial begin
    int c0, p0;
    rst_n = 1'b0; i_start = 1'b0; i_result_ready = 1'b1; salt = 16'h0;
    s5_start = 1'b0; s5_ready = 1'b1;
    repeat (2) step();
    chk("rst_busy", o_busy, 0);
    chk("rst_clear", o_clear, 0);
    chk("rst_pix", o_pixel_req, 0);
    chk("rst_valid", o_result_valid, 0);
    chk("rst_addr", o_weight_addr, 0);
    chk("rst_rowcol", {o_tap_row, o_tap_col}, 0);
    chk("rst_bus", o_result_bus, 0);
    chk("rst_bus5", b5_bus, 0);
    rst_n = 1'b1;
    step();
    chk("idle_after_rst", o_busy, 0);

    do_job(0, -1, 1'b0, 1'b0);

    salt = 16'h0020;
    do_job(5, -1, 1'b0, 1'b0);

    salt = 16'h0300;
    c0 = clr_seen; p0 = pix_seen;
    do_job(0, 4, 1'b0, 1'b0);
    chk("one_clear", clr_seen - c0, 1);
    chk("nine_taps", pix_seen - p0, 9);
    repeat (3) step();
    chk("start_not_queued", o_busy, 0);

    salt = 16'h0040;
    do_job(0, -1, 1'b0, 1'b1);
    salt = 16'h0500;
    do_job(0, -1, 1'b1, 1'b0);

    salt = 16'h0077;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    repeat (4) step();
    chk("pre_rst_tap4", o_weight_addr, 4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_pix", o_pixel_req, 0);
    chk("mid_rst_clear", o_clear, 0);
    chk("mid_rst_valid", o_result_valid, 0);
    chk("mid_rst_taps", {o_weight_addr, o_tap_row, o_tap_col}, 0);
    chk("mid_rst_bus", o_result_bus, 0);
    step();
    chk("mid_rst_idle", o_busy, 0);
    c0 = clr_seen; p0 = pix_seen;
    do_job(0, -1, 1'b0, 1'b0);
    chk("rst_job_clear", clr_seen - c0, 1);
    chk("rst_job_taps", pix_seen - p0, 9);

    salt = 16'h0A00;
    s5_start = 1'b1;
    step();
    s5_start = 1'b0;
    chk("k5_clear", b5_clear, 1);
    step();
    for (int t = 0; t < 25; t++) begin
      chk("k5_pix", b5_pix, 1);
      chk("k5_addr", b5_addr, t);
      chk("k5_row", b5_row, t / 5);
      chk("k5_col", b5_col, t % 5);
      step();
    end
    for (int d = 0; d < 3; d++) begin
      chk("k5_drain_pix", b5_pix, 0);
      chk("k5_drain_valid", b5_valid, 0);
      step();
    end
    chk("k5_valid_n30", b5_valid, 1);
    chk("k5_bus", b5_bus, model(16'h0A00));
    step();
    chk("k5_idle", b5_busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/conv_array_ctrl.md
CONV_ARRAY_CTRL -- requirements
Module: conv_array_ctrl

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 6, number of kernels on the pixel bus.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3, convolution window edge; taps per job = KERNEL_SIZE*KERNEL_SIZE (9).
REQ-003 SHALL have parameter MAC_LATENCY, default 2, cycles from the last tap presented to a valid array output.
REQ-004 SHALL size all data at `DATA_WIDTH; TAP_W = clog2(KERNEL_SIZE*KERNEL_SIZE), IDX_W = clog2(KERNEL_SIZE).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port i_start, input, 1, job request, sampled only in IDLE.
REQ-008 SHALL have port o_busy, output, 1, high whenever state is not IDLE.
REQ-009 SHALL have port o_clear, output, 1, accumulator clear to the kernel array.
REQ-010 SHALL have port o_pixel_req, output, 1, upstream drives the pixel bus and weight for the current tap this cycle.
REQ-011 SHALL have port o_weight_addr, output, TAP_W, weight memory address = tap index.
REQ-012 SHALL have ports o_tap_row and o_tap_col, output, IDX_W each, window offset of the current tap for the line cache.
REQ-013 SHALL have port i_array_bus, input, ARRAY_SIZE*`DATA_WIDTH, kernel array output bus.
REQ-014 SHALL have port o_result_bus, output, ARRAY_SIZE*`DATA_WIDTH, captured result.
REQ-015 SHALL have ports o_result_valid (output, 1) and i_result_ready (input, 1), valid/ready result handshake.

Function
REQ-016 SHALL implement states IDLE, CLEAR, ACCUM, DRAIN, OUTPUT.
REQ-017 IDLE: i_start=1 -> CLEAR; otherwise stay.
REQ-018 CLEAR: exactly 1 cycle, o_clear=1 -> ACCUM.
REQ-019 ACCUM: exactly KERNEL_SIZE^2 cycles, o_pixel_req=1, tap index 0..KERNEL_SIZE^2-1 ascending, row-major (col increments, wraps to 0 and increments row).
REQ-020 o_weight_addr, o_tap_row, o_tap_col SHALL be registered and valid in the same cycle as o_pixel_req; 0 outside ACCUM.
REQ-021 Row/col SHALL be kept as separate counters; no divider or modulo logic.
REQ-022 DRAIN: exactly MAC_LATENCY cycles; on the clock edge ending the last DRAIN cycle, i_array_bus SHALL be captured into o_result_bus -> OUTPUT.
REQ-023 OUTPUT: o_result_valid=1 and o_result_bus stable until i_result_ready=1; on handshake, if i_start=1 the same cycle -> CLEAR (back-to-back), else -> IDLE.
REQ-024 With defaults, i_start sampled in cycle N gives o_clear in N+1, taps in N+2..N+10, o_result_valid first high in N+13.
REQ-025 i_start in any state other than IDLE, or in OUTPUT without handshake, SHALL be ignored (not queued).
REQ-026 o_clear and o_pixel_req SHALL never be high in the same cycle.
REQ-027 o_result_bus SHALL hold its last captured value in IDLE.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, zero tap/row/col/drain counters, o_result_bus=0, and all 1-bit outputs 0, from any state including mid-ACCUM and mid-OUTPUT.
REQ-029 The first i_start after reset release SHALL follow REQ-024 timing exactly.

Structure
REQ-030 State encodings, KERNEL_SIZE, MAC_LATENCY defaults, and TAP_W/IDX_W SHALL live in the shared conv kernel parameter include, not in the module.
REQ-031 The row/col/tap counting SHALL be one sub-module, conv_tap_counter (inputs clear, enable; outputs tap, row, col, last).

Verification
REQ-032 Single job, array model returns 0x0101*k per lane k, ready tied 1 -> valid at N+13 for one cycle, bus matches model, tap sequence (0,0)..(2,2), addresses 0..8.
REQ-033 Ready held 0 for 5 cycles after valid -> valid and bus unchanged for 6 cycles, IDLE next cycle after handshake.
REQ-034 i_start pulsed during ACCUM tap 4 -> ignored; exactly one clear and 9 taps observed.
REQ-035 i_start=1 and ready=1 together in OUTPUT -> o_clear the next cycle, second result at 13 cycles after the handshake cycle.
REQ-036 rst_n=0 for one cycle at tap 4 -> all outputs 0 the next cycle, o_busy=0; a following start yields a full 9-tap job.
REQ-037 Parameter sweep KERNEL_SIZE=5, MAC_LATENCY=3 -> 25 taps, valid at N+30.
